// File: rtl/cmd_physic_block_control.sv
`default_nettype none
// ============================================================================
// Module   : cmd_physic_block_control
// Brief    : Control FSM for the SD-card CMD-line physical layer. Sequences
//            the PTS/STP wrappers and CMD pad direction, captures the 38-bit
//            card response or flags a timeout, and hands the result to the
//            upper layer through a strobe/ack/idle handshake.
// Revision : 1.0 - initial release
// ============================================================================
module cmd_physic_block_control #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 16
) (
    input  logic        iClock_SD,
    input  logic        iReset,
    input  logic        iStrobe_in,
    input  logic        iTransmission_complete,
    input  logic        iReception_complete,
    input  logic        iNo_response,
    input  logic [37:0] iPad_response,
    input  logic        iAck_in,
    input  logic        iIdle_in,
    output logic        oReset_wrapper,
    output logic        oEnable_PTS_wrapper,
    output logic        oEnable_STP_wrapper,
    output logic        oPad_stable,
    output logic        oPad_enable,
    output logic        oLoad_send,
    output logic        oStrobe_out,
    output logic        oCommand_timeout,
    output logic [37:0] oResponse,
    output logic        oAck_out
);

    // Counter value on the last cycle of the response window.
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_RESET         = 3'd0,
        ST_IDLE          = 3'd1,
        ST_SEND_COMMAND  = 3'd2,
        ST_WAIT_RESPONSE = 3'd3,
        ST_SEND_RESPONSE = 3'd4,
        ST_WAIT_IDLE     = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic               first_q, first_d;     // high on the first cycle spent in a state
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic [37:0]        resp_q,  resp_d;
    logic               tmo_q,   tmo_d;

    // Next-state, counter and result-register computation.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        resp_d  = resp_q;
        tmo_d   = tmo_q;
        case (state_q)
            ST_RESET: begin
                state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (iStrobe_in) begin
                    state_d = ST_SEND_COMMAND;
                    tmo_d   = 1'b0;
                    resp_d  = '0;
                end
            end
            ST_SEND_COMMAND: begin
                if (iTransmission_complete) begin
                    state_d = iNo_response ? ST_SEND_RESPONSE : ST_WAIT_RESPONSE;
                end
            end
            ST_WAIT_RESPONSE: begin
                cnt_d = cnt_q + CNT_W'(1);
                // A response arriving on the final window cycle beats the timeout.
                if (iReception_complete) begin
                    resp_d  = iPad_response;
                    state_d = ST_SEND_RESPONSE;
                end else if (cnt_q == C_CNT_LAST) begin
                    tmo_d   = 1'b1;
                    state_d = ST_SEND_RESPONSE;
                end
            end
            ST_SEND_RESPONSE: begin
                if (iAck_in) begin
                    state_d = ST_WAIT_IDLE;
                end
            end
            ST_WAIT_IDLE: begin
                if (iIdle_in) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_RESET;
            end
        endcase
        first_d = (state_d != state_q);
    end

    // State and result registers; reset forces the RESET state immediately.
    always_ff @(posedge iClock_SD or posedge iReset) begin
        if (iReset) begin
            state_q <= ST_RESET;
            first_q <= 1'b0;
            cnt_q   <= '0;
            resp_q  <= '0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            first_q <= first_d;
            cnt_q   <= cnt_d;
            resp_q  <= resp_d;
            tmo_q   <= tmo_d;
        end
    end

    // Moore output decode from registered state only; no input reaches an output.
    always_comb begin
        oReset_wrapper      = 1'b0;
        oEnable_PTS_wrapper = 1'b0;
        oEnable_STP_wrapper = 1'b0;
        oPad_stable         = 1'b0;
        oPad_enable         = 1'b0;
        oLoad_send          = 1'b0;
        oStrobe_out         = 1'b0;
        oAck_out            = 1'b0;
        case (state_q)
            ST_RESET: begin
                oReset_wrapper = 1'b1;
            end
            ST_SEND_COMMAND: begin
                oEnable_PTS_wrapper = 1'b1;
                oPad_enable         = 1'b1;
                oLoad_send          = first_q;
                oAck_out            = first_q;
                oPad_stable         = ~first_q;   // first cycle is pad turnaround
            end
            ST_WAIT_RESPONSE: begin
                oEnable_STP_wrapper = 1'b1;
                oPad_stable         = ~first_q;
            end
            ST_SEND_RESPONSE: begin
                oStrobe_out = 1'b1;
            end
            default: begin
            end
        endcase
        oCommand_timeout = tmo_q;
        oResponse        = resp_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_cmd_physic_block_control.sv
`default_nettype none
// ============================================================================
// Module   : tb_cmd_physic_block_control
// Brief    : Self-checking bench for cmd_physic_block_control: a table of
//            command transactions plus hand-written reset sequences, with a
//            scoreboard queue of expected results.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cmd_physic_block_control;

    localparam int TMO = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        strobe = 1'b0, txc = 1'b0, rxc = 1'b0, nores = 1'b0;
    logic [37:0] pad = '0;
    logic        ack = 1'b0, idle = 1'b0;

    logic        o_rstw, o_pts, o_stp, o_stable, o_paden, o_load, o_strb, o_tmo, o_ack;
    logic [37:0] o_resp;
    logic [8:0]  outs;

    assign outs = {o_rstw, o_pts, o_stp, o_stable, o_paden, o_load, o_strb, o_tmo, o_ack};

    cmd_physic_block_control #(.TIMEOUT_CYCLES(TMO), .CNT_W(16)) dut (
        .iClock_SD              (clk),
        .iReset                 (rst),
        .iStrobe_in             (strobe),
        .iTransmission_complete (txc),
        .iReception_complete    (rxc),
        .iNo_response           (nores),
        .iPad_response          (pad),
        .iAck_in                (ack),
        .iIdle_in               (idle),
        .oReset_wrapper         (o_rstw),
        .oEnable_PTS_wrapper    (o_pts),
        .oEnable_STP_wrapper    (o_stp),
        .oPad_stable            (o_stable),
        .oPad_enable            (o_paden),
        .oLoad_send             (o_load),
        .oStrobe_out            (o_strb),
        .oCommand_timeout       (o_tmo),
        .oResponse              (o_resp),
        .oAck_out               (o_ack)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic        tmo;
        logic [37:0] resp;
    } exp_t;
    exp_t sb[$];

    // One transaction: rx_d < 0 means the card never answers.
    typedef struct {
        bit          nr;
        int          tx_d;
        int          rx_d;
        logic [37:0] resp;
        bit          sw;        // pulse iStrobe_in while waiting for the response
        int          ack_hold;
        bit          exp_to;
        logic [37:0] exp_resp;
    } vec_t;
    vec_t tbl[6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_txn(input vec_t t);
        exp_t e;
        int   waited;
        int   exp_lat;
        strobe = 1'b1;
        tick();
        strobe = 1'b0;
        check("cmd_first_cycle", 64'(outs), 64'(9'b010011001));
        check("resp_cleared", 64'(o_resp), 64'd0);
        tick();
        check("cmd_second_cycle", 64'(outs), 64'(9'b010110000));
        repeat (t.tx_d) tick();
        txc   = 1'b1;
        nores = t.nr;
        tick();
        txc   = 1'b0;
        nores = 1'b0;
        if (t.nr) begin
            sb.push_back('{1'b0, 38'd0});
            check("nores_stp_off", 64'(o_stp), 64'd0);
        end else begin
            sb.push_back('{t.exp_to, t.exp_resp});
            check("wait_first_cycle", 64'(outs), 64'(9'b001000000));
            waited  = 0;
            exp_lat = t.exp_to ? TMO : t.rx_d + 1;
            while (!o_strb && waited < 200) begin
                if (waited == t.rx_d) begin
                    rxc = 1'b1;
                    pad = t.resp;
                end
                if (waited == 1 && t.sw) strobe = 1'b1;
                tick();
                waited++;
                rxc    = 1'b0;
                pad    = {6'($urandom()), $urandom()};
                if (waited == 2 && t.sw) begin
                    strobe = 1'b0;
                    check("strobe_ignored_in_wait", 64'({o_load, o_ack, o_pts}), 64'd0);
                end
                if (waited == 1 && !o_strb)
                    check("wait_second_cycle", 64'(outs), 64'(9'b001100000));
            end
            check("strobe_latency", 64'(waited), 64'(exp_lat));
        end
        check("strobe_out_high", 64'(o_strb), 64'd1);
        check("send_resp_enables", 64'({o_pts, o_stp, o_paden}), 64'd0);
        if (sb.size() == 0) begin
            check("scoreboard_empty", 64'd1, 64'd0);
        end else begin
            e = sb.pop_front();
            check("timeout_flag", 64'(o_tmo), 64'(e.tmo));
            check("response", 64'(o_resp), 64'(e.resp));
        end
        repeat (t.ack_hold) tick();
        check("strobe_held", 64'(o_strb), 64'd1);
        ack = 1'b1;
        tick();
        check("ack_drops_strobe", 64'(outs), 64'({7'd0, t.exp_to, 1'b0}));
        // Ack stays high and a stray strobe arrives while in WAIT_IDLE.
        strobe = 1'b1;
        tick();
        check("wait_idle_holds", 64'(outs), 64'({7'd0, t.exp_to, 1'b0}));
        ack    = 1'b0;
        strobe = 1'b0;
        idle   = 1'b1;
        tick();
        idle   = 1'b0;
        tick();
        check("idle_outputs", 64'(outs), 64'({7'd0, t.exp_to, 1'b0}));
        check("resp_held_in_idle", 64'(o_resp), 64'(t.exp_resp));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{1'b0, 38, 5,  38'h2A_5A5A_5A5A, 1'b0, 10, 1'b0, 38'h2A_5A5A_5A5A};
        tbl[1] = '{1'b1, 3,  -1, 38'h0,            1'b0, 2,  1'b0, 38'h0};
        tbl[2] = '{1'b0, 1,  -1, 38'h0,            1'b1, 0,  1'b1, 38'h0};
        tbl[3] = '{1'b0, 2,  63, 38'h15_0F0F_1234, 1'b0, 1,  1'b0, 38'h15_0F0F_1234};
        tbl[4] = '{1'b0, 0,  62, 38'h3F_FFFF_FFFF, 1'b0, 0,  1'b0, 38'h3F_FFFF_FFFF};
        tbl[5] = '{1'b0, 0,  0,  38'h00_0000_0001, 1'b1, 3,  1'b0, 38'h00_0000_0001};

        // Power-on reset, then release: one cycle in RESET, then IDLE.
        tick();
        tick();
        check("por_outputs", 64'(outs), 64'(9'b100000000));
        check("por_response", 64'(o_resp), 64'd0);
        rst = 1'b0;
        #1;
        check("reset_state_one_cycle", 64'(outs), 64'(9'b100000000));
        tick();
        check("idle_after_reset", 64'(outs), 64'd0);

        foreach (tbl[i]) run_txn(tbl[i]);

        // Asynchronous reset in the middle of SEND_COMMAND.
        strobe = 1'b1;
        tick();
        strobe = 1'b0;
        tick();
        check("pre_reset_cmd", 64'(outs), 64'(9'b010110000));
        #3 rst = 1'b1;
        #1;
        check("async_reset_outputs", 64'(outs), 64'(9'b100000000));
        check("async_reset_resp", 64'(o_resp), 64'd0);
        tick();
        rst = 1'b0;
        tick();
        check("idle_after_midreset", 64'(outs), 64'd0);
        tick();
        check("stays_idle", 64'(outs), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cmd_physic_block_control.md
# cmd_physic_block_control

Control FSM for the SD-card command-line physical layer. It accepts a command strobe from the upper layer and sequences the parallel-to-serial (PTS) and serial-to-parallel (STP) wrappers and the CMD pad direction. It captures the 38-bit card response or flags a timeout, then returns the result to the upper layer through a strobe/ack/idle handshake. It sits between the command-layer controller and the PTS/STP wrappers plus the CMD pad driver.

## Interface
Parameters:
- TIMEOUT_CYCLES, 64: cycles waited in WAIT_RESPONSE before declaring a timeout (≥2).
- CNT_W, 16: width of the timeout counter.

Ports:
- iClock_SD  in  1  SD clock; the only clock, all state changes on its rising edge.
- iReset  in  1  asynchronous, active-high reset.
- iStrobe_in  in  1  upper layer requests a command transaction.
- iTransmission_complete  in  1  PTS wrapper finished shifting the command out.
- iReception_complete  in  1  STP wrapper holds a complete response on iPad_response.
- iNo_response  in  1  current command expects no response; sampled with iTransmission_complete.
- iPad_response  in  38  parallel response from the STP wrapper.
- iAck_in  in  1  upper layer acknowledges oStrobe_out.
- iIdle_in  in  1  upper layer releases the block back to IDLE.
- oReset_wrapper  out  1  resets the PTS/STP wrappers.
- oEnable_PTS_wrapper  out  1  enables the serializer.
- oEnable_STP_wrapper  out  1  enables the deserializer.
- oPad_stable  out  1  pad direction settled; data on CMD is valid.
- oPad_enable  out  1  1 = drive CMD pad (output), 0 = pad is input.
- oLoad_send  out  1  one-cycle load pulse for the PTS shift register.
- oStrobe_out  out  1  response/result available to the upper layer.
- oCommand_timeout  out  1  last command got no response within TIMEOUT_CYCLES.
- oResponse  out  38  captured response.
- oAck_out  out  1  one-cycle acknowledge that iStrobe_in was accepted.

## Operation
- The FSM has the states RESET, IDLE, SEND_COMMAND, WAIT_RESPONSE, SEND_RESPONSE and WAIT_IDLE.
- Outputs are Moore decodes of the registered state, the in-state first-cycle flag, the counter and the registered oResponse/oCommand_timeout. There is no combinational path from any input to any output.
- RESET: oReset_wrapper=1, all other control outputs 0. Next state is always IDLE.
- IDLE: all control outputs 0. On iStrobe_in=1, go to SEND_COMMAND, clear oCommand_timeout and clear oResponse to 0.
- SEND_COMMAND: oEnable_PTS_wrapper=1 and oPad_enable=1.
  - oLoad_send=1 and oAck_out=1 on the first cycle in the state only.
  - oPad_stable=1 from the second cycle onward (first cycle is the pad turnaround).
  - On iTransmission_complete=1: go to SEND_RESPONSE if iNo_response=1, otherwise go to WAIT_RESPONSE with the counter cleared.
- WAIT_RESPONSE: oEnable_STP_wrapper=1 and oPad_enable=0. oPad_stable=1 from the second cycle. The counter increments every cycle.
  - On iReception_complete=1: oResponse <= iPad_response, go to SEND_RESPONSE.
  - Else, when the counter reaches TIMEOUT_CYCLES-1: oCommand_timeout <= 1, oResponse unchanged (0), go to SEND_RESPONSE.
  - If iReception_complete arrives in the same cycle the timeout would fire, reception wins and no timeout is flagged.
- SEND_RESPONSE: oStrobe_out=1 and all wrapper enables 0. Hold until iAck_in=1, then go to WAIT_IDLE.
- WAIT_IDLE: oStrobe_out=0. On iIdle_in=1, go to IDLE.
- oResponse and oCommand_timeout hold their values from SEND_RESPONSE until the next command is accepted in IDLE.
- iStrobe_in is ignored outside IDLE. Other inputs are ignored outside the states that sample them.

## Timing
- Async reset: the state becomes RESET immediately. oReset_wrapper=1, every other output 0, oResponse=0, counter=0.
- After iReset deasserts: 1 cycle in RESET, then IDLE on the next edge.
- Reset mid-transaction behaves exactly like a power-on reset.
- Strobe-to-load latency: iStrobe_in sampled high at edge N gives oLoad_send=oAck_out=1 during cycle N..N+1. oPad_stable rises after edge N+1.
- Transmission complete to STP enable: 1 edge.
- Reception complete to oStrobe_out=1 with valid oResponse: 1 edge.
- Timeout: oStrobe_out rises exactly TIMEOUT_CYCLES edges after entering WAIT_RESPONSE.
- oStrobe_out is level-held while awaiting iAck_in. iAck_in held high across states has no further effect.

## Test plan
- Reset: assert iReset mid-cycle -> outputs go 0 and oReset_wrapper=1 asynchronously. Release -> IDLE after 1 cycle, all outputs 0.
- Normal command: strobe in IDLE, then iTransmission_complete after 40 cycles, then iReception_complete with iPad_response=38'h2A_5A5A_5A5A -> one-cycle oLoad_send/oAck_out, oPad_enable 1 then 0, oStrobe_out=1, oResponse=38'h2A_5A5A_5A5A, oCommand_timeout=0.
- No-response command: iNo_response=1 with iTransmission_complete -> SEND_RESPONSE in 1 cycle, oEnable_STP_wrapper never 1, oResponse=0.
- Timeout: no iReception_complete -> oCommand_timeout=1 and oStrobe_out=1 exactly 64 cycles after entering WAIT_RESPONSE. The next strobe clears oCommand_timeout.
- Handshake: hold iAck_in low for 10 cycles -> oStrobe_out stays 1. Raise iAck_in -> oStrobe_out=0. The block stays in WAIT_IDLE and ignores iStrobe_in until iIdle_in=1.
- Boundary: iReception_complete on the timeout cycle -> response captured, oCommand_timeout=0. iStrobe_in pulsed during WAIT_RESPONSE -> ignored.
